databus_arbiter: RTL and testbench

Parametrised, registered successor to the CPU's combinational datapath bus mux. It gates one of NUM_SRC source words onto the shared internal data bus, using per-source gate requests instead of an encoded select. It arbitrates simultaneous gates by fixed priority or round-robin, optionally keeps the last bus value when nothing drives, and flags and counts bus contention for debug. It sits between the datapath sources (MARMUX, PC, ALU, MDR and any added units) and every bus consumer.

---
 rtl/databus_arbiter.sv | 79 +++++++
 tb/tb_databus_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/databus_arbiter.sv
// Registered internal data bus: gates one of NUM_SRC source words onto dout,
// arbitrating simultaneous gate requests by fixed priority or round-robin, with contention debug.
module databus_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int RR_MODE = 0,
  parameter int HOLD_EN = 1,
  parameter int CNT_W   = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_SRC*WIDTH-1:0] din,
  input  logic [NUM_SRC-1:0]       gate,
  input  logic                     clear_cnt,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     conflict,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]      ptr, ptr_nxt;
  logic [NUM_SRC-1:0] gnt;
  logic [WIDTH-1:0]   word;
  logic               found;
  logic               multi;
  int                 start, idx, win;

  // Search from the start index with explicit modulo so non-power-of-two sizes wrap cleanly.
  always_comb begin
    gnt   = '0;
    word  = '0;
    found = 1'b0;
    win   = 0;
    idx   = 0;
    start = (RR_MODE != 0) ? int'(ptr) : 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (start + k) % NUM_SRC;
      if (!found && gate[idx]) begin
        found    = 1'b1;
        win      = idx;
        gnt[idx] = 1'b1;
        word     = din[idx*WIDTH +: WIDTH];
      end
    end
    ptr_nxt = PW'((win + 1) % NUM_SRC);
  end

  // Two or more bits set iff clearing the lowest set bit leaves something behind.
  assign multi = (gate & (gate - NUM_SRC'(1))) != '0;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      dout         <= '0;
      dout_valid   <= 1'b0;
      grant        <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
      ptr          <= '0;
    end else begin
      grant      <= gnt;
      dout_valid <= found;
      conflict   <= multi;
      if (found) begin
        dout <= word;
        if (RR_MODE != 0) ptr <= ptr_nxt;
      end else if (HOLD_EN == 0) begin
        dout <= '0;
      end
      if (clear_cnt)
        conflict_cnt <= '0;
      else if (multi && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_databus_arbiter.sv
// Directed bench: table of vectors for the default/no-hold arbiters, plus hand sequences
// for round-robin order, 3-source wrap, counter saturation/clear and mid-stream reset.
module tb_databus_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [63:0] din4;
  logic [3:0]  gate4;
  logic        clr;
  logic [47:0] din3;
  logic [2:0]  gate3;

  logic [15:0] d0, d1, d2, d3, d4;
  logic        v0, v1, v2, v3, v4;
  logic [3:0]  g0, g1, g2, g4;
  logic [2:0]  g3;
  logic        c0, c1, c2, c3, c4;
  logic [7:0]  n0, n1, n2, n3;
  logic [1:0]  n4;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  databus_arbiter u0 (.Clk(Clk), .Reset(Reset), .din(din4), .gate(gate4), .clear_cnt(clr),
    .dout(d0), .dout_valid(v0), .grant(g0), .conflict(c0), .conflict_cnt(n0));
  databus_arbiter #(.HOLD_EN(0)) u1 (.Clk(Clk), .Reset(Reset), .din(din4), .gate(gate4),
    .clear_cnt(clr), .dout(d1), .dout_valid(v1), .grant(g1), .conflict(c1), .conflict_cnt(n1));
  databus_arbiter #(.RR_MODE(1)) u2 (.Clk(Clk), .Reset(Reset), .din(din4), .gate(gate4),
    .clear_cnt(clr), .dout(d2), .dout_valid(v2), .grant(g2), .conflict(c2), .conflict_cnt(n2));
  databus_arbiter #(.RR_MODE(1), .NUM_SRC(3)) u3 (.Clk(Clk), .Reset(Reset), .din(din3),
    .gate(gate3), .clear_cnt(clr), .dout(d3), .dout_valid(v3), .grant(g3), .conflict(c3),
    .conflict_cnt(n3));
  databus_arbiter #(.CNT_W(2)) u4 (.Clk(Clk), .Reset(Reset), .din(din4), .gate(gate4),
    .clear_cnt(clr), .dout(d4), .dout_valid(v4), .grant(g4), .conflict(c4), .conflict_cnt(n4));

  typedef struct {
    logic        rst;
    logic [3:0]  gate;
    logic        clr;
    logic [63:0] din;
    logic [15:0] dout;
    logic [15:0] dout_h0;
    logic        vld;
    logic [3:0]  grant;
    logic        conf;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  localparam logic [63:0] DA = 64'h3333_A5A5_1111_0BEE;
  localparam logic [63:0] DB = 64'h3333_A5A5_1111_CAFE;

  initial begin
    //            rst  gate    clr  din dout      dout_h0   vld  grant   conf cnt
    tbl[0]  = '{1'b0, 4'b1111, 1'b0, DA, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, DA, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 4'b0000, 1'b0, DA, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 4'b0100, 1'b0, DA, 16'hA5A5, 16'hA5A5, 1'b1, 4'b0100, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 4'b0000, 1'b0, DA, 16'hA5A5, 16'h0000, 1'b0, 4'b0000, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 4'b1010, 1'b0, DA, 16'h1111, 16'h1111, 1'b1, 4'b0010, 1'b1, 8'd1};
    tbl[6]  = '{1'b1, 4'b1010, 1'b1, DA, 16'h1111, 16'h1111, 1'b1, 4'b0010, 1'b1, 8'd0};
    tbl[7]  = '{1'b1, 4'b1000, 1'b0, DA, 16'h3333, 16'h3333, 1'b1, 4'b1000, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 4'b0001, 1'b0, DA, 16'h0BEE, 16'h0BEE, 1'b1, 4'b0001, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 4'b0001, 1'b0, DB, 16'hCAFE, 16'hCAFE, 1'b1, 4'b0001, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 4'b0111, 1'b0, DB, 16'hCAFE, 16'hCAFE, 1'b1, 4'b0001, 1'b1, 8'd1};
    tbl[11] = '{1'b1, 4'b1100, 1'b0, DB, 16'hA5A5, 16'hA5A5, 1'b1, 4'b0100, 1'b1, 8'd2};
    tbl[12] = '{1'b1, 4'b0000, 1'b0, DB, 16'hA5A5, 16'h0000, 1'b0, 4'b0000, 1'b0, 8'd2};

    Reset = 1'b0; gate4 = '0; gate3 = '0; clr = 1'b0; din4 = DA;
    din3 = 48'h3C3C_2B2B_1A1A;

    for (int i = 0; i < 13; i++) begin
      Reset = tbl[i].rst; gate4 = tbl[i].gate; clr = tbl[i].clr; din4 = tbl[i].din;
      step();
      chk($sformatf("v%0d dout", i), d0, tbl[i].dout);
      chk($sformatf("v%0d dout_nohold", i), d1, tbl[i].dout_h0);
      chk($sformatf("v%0d valid", i), v0, tbl[i].vld);
      chk($sformatf("v%0d grant", i), g0, tbl[i].grant);
      chk($sformatf("v%0d conflict", i), c0, tbl[i].conf);
      chk($sformatf("v%0d cnt", i), n0, tbl[i].cnt);
    end

    // Round-robin order (4 sources) and wrap (3 sources) from a fresh reset.
    Reset = 1'b0; gate4 = '0; gate3 = '0; clr = 1'b0; din4 = DA;
    step();
    chk("rr reset grant", g2, 4'b0000);
    chk("rr3 reset grant", g3, 3'b000);
    Reset = 1'b1; gate4 = 4'b1111; gate3 = 3'b111;
    begin
      logic [3:0]  exp4 [6];
      logic [2:0]  exp3 [6];
      logic [15:0] expd [6];
      logic [15:0] exp3d [6];
      exp4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      expd = '{16'h0BEE, 16'h1111, 16'hA5A5, 16'h3333, 16'h0BEE, 16'h1111};
      exp3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp3d = '{16'h1A1A, 16'h2B2B, 16'h3C3C, 16'h1A1A, 16'h2B2B, 16'h3C3C};
      for (int i = 0; i < 6; i++) begin
        step();
        chk($sformatf("rr grant %0d", i), g2, exp4[i]);
        chk($sformatf("rr dout %0d", i), d2, expd[i]);
        chk($sformatf("rr3 grant %0d", i), g3, exp3[i]);
        chk($sformatf("rr3 dout %0d", i), d3, exp3d[i]);
      end
    end
    chk("rr conflict", c2, 1'b1);
    chk("rr cnt", n2, 8'd6);

    // Mid-stream reset: ptr at 3 after granting 2, then reset must restart at source 0.
    gate4 = 4'b0100; gate3 = '0;
    step();
    chk("rr pre-reset grant", g2, 4'b0100);
    Reset = 1'b0; gate4 = 4'b1111;
    step();
    chk("rr in-reset grant", g2, 4'b0000);
    chk("rr in-reset dout", d2, 16'h0000);
    chk("rr in-reset valid", v2, 1'b0);
    Reset = 1'b1;
    step();
    chk("rr post-reset grant", g2, 4'b0001);
    chk("rr post-reset dout", d2, 16'h0BEE);

    // Saturating 2-bit counter, then clear wins over a contention cycle.
    Reset = 1'b0; gate4 = '0;
    step();
    chk("sat reset cnt", n4, 2'd0);
    Reset = 1'b1; gate4 = 4'b0011;
    begin
      logic [1:0] expn [5];
      expn = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        step();
        chk($sformatf("sat cnt %0d", i), n4, expn[i]);
      end
    end
    clr = 1'b1;
    step();
    chk("clr cnt", n4, 2'd0);
    chk("clr conflict", c4, 1'b1);
    chk("clr grant", g4, 4'b0001);
    clr = 1'b0; gate4 = 4'b0000;
    step();
    chk("post-clr cnt", n4, 2'd0);
    chk("post-clr conflict", c4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
